double_unit_arbiter: RTL and testbench

//  Shares one fixed-latency, pipelined double-precision unary unit (double_neg or any
//  1-in/1-out double op without handshake) between N_REQ requesters. Round-robin

---
 rtl/double_pkg.sv | 23 ++
 rtl/double_result_fifo.sv | 65 ++++++
 rtl/double_unit_arbiter.sv | 123 ++++++++++++
 tb/tb_double_unit_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/double_pkg.sv
// rtl/double_pkg.sv - shared widths, constants and helpers for the double unit arbiter
package double_pkg;

   localparam int DOUBLE_W = 64;

   // IEEE-754 double +1.0 and -1.0
   localparam logic [DOUBLE_W-1:0] POS_ONE = 64'h3FF0000000000000;
   localparam logic [DOUBLE_W-1:0] NEG_ONE = 64'hBFF0000000000000;

   // ceiling log2; returns 0 for values <= 1
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/double_result_fifo.sv
// rtl/double_result_fifo.sv - result FIFO holding {tag, data} with occupancy count
module double_result_fifo
   import double_pkg::*;
#(
   parameter  int WIDTH = DOUBLE_W + 2,
   parameter  int DEPTH = 4,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             empty;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign do_rd = rd_en && !empty;
   // a full FIFO may still accept a write when the head leaves in the same cycle;
   // the head is read combinationally before the edge overwrites its slot
   assign do_wr = wr_en && (!full || do_rd);

   // storage has no reset: an entry is only visible between its write and its read
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // pointers and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_wr && !do_rd) begin
            count <= count + 1'b1;
         end else if (do_rd && !do_wr) begin
            count <= count - 1'b1;
         end
      end
   end

   // head entry, forced to zero while empty so stale slots never leak out
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/double_unit_arbiter.sv
// rtl/double_unit_arbiter.sv - round-robin sharing of one pipelined double unit with credit-gated results
module double_unit_arbiter
   import double_pkg::*;
#(
   parameter  int N_REQ      = 4,
   parameter  int LATENCY    = 1,
   parameter  int FIFO_DEPTH = 4,
   localparam int TAG_W      = clog2(N_REQ),
   localparam int CNT_W      = clog2(FIFO_DEPTH + 1),
   localparam int INF_W      = clog2(LATENCY + 1),
   localparam int OCC_W      = clog2(FIFO_DEPTH + LATENCY + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [DOUBLE_W*N_REQ-1:0] req_data,
   output logic [DOUBLE_W-1:0]       unit_a,
   input  logic [DOUBLE_W-1:0]       unit_z,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DOUBLE_W-1:0]       rsp_data,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      busy
);

   logic [TAG_W-1:0]          rr_ptr;
   logic [TAG_W-1:0]          grant_idx;
   logic                      issue_ok;
   logic                      issue;
   logic [LATENCY-1:0]        pipe_v;
   logic [TAG_W-1:0]          pipe_tag [LATENCY];
   logic [INF_W-1:0]          inflight;
   logic [OCC_W-1:0]          occupancy;
   logic [CNT_W-1:0]          fifo_count;
   logic [TAG_W+DOUBLE_W-1:0] fifo_head;

   // count ops still travelling through the unit
   always_comb begin
      inflight = '0;
      for (int s = 0; s < LATENCY; s++) begin
         inflight = inflight + INF_W'(pipe_v[s]);
      end
   end

   // every op in flight already owns a FIFO slot, so the FIFO can never overflow
   assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
   assign issue_ok  = occupancy < OCC_W'(FIFO_DEPTH);

   // round-robin pick: lowest valid lane at or above rr_ptr, else lowest valid lane (wrap)
   always_comb begin
      grant_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_idx = TAG_W'(i);
         end
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (TAG_W'(i) >= rr_ptr)) begin
            grant_idx = TAG_W'(i);
         end
      end
   end

   // reset also masks the grant so every output reads zero while rst_n is low
   assign issue = rst_n && issue_ok && (|req_valid);

   // one-hot grant and operand mux towards the unit
   always_comb begin
      req_ready = '0;
      unit_a    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (issue && (TAG_W'(i) == grant_idx)) begin
            req_ready[i] = 1'b1;
            unit_a       = req_data[DOUBLE_W*i +: DOUBLE_W];
         end
      end
   end

   // rotate priority to the lane after the one just served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (issue) begin
         rr_ptr <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // valid/tag shadow of the unit pipeline, shifting every edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         for (int s = 0; s < LATENCY; s++) begin
            pipe_tag[s] <= '0;
         end
      end else begin
         pipe_v[0]   <= issue;
         pipe_tag[0] <= grant_idx;
         for (int s = 1; s < LATENCY; s++) begin
            pipe_v[s]   <= pipe_v[s-1];
            pipe_tag[s] <= pipe_tag[s-1];
         end
      end
   end

   double_result_fifo #(
      .WIDTH (TAG_W + DOUBLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_result_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (pipe_v[LATENCY-1]),
      .wr_data ({pipe_tag[LATENCY-1], unit_z}),
      .rd_en   (rsp_valid && rsp_ready),
      .rd_data (fifo_head),
      .count   (fifo_count)
   );

   assign rsp_valid           = (fifo_count != '0);
   assign {rsp_tag, rsp_data} = fifo_head;
   assign busy                = (|pipe_v) || rsp_valid;

endmodule

// File: tb/tb_double_unit_arbiter.sv
// tb/tb_double_unit_arbiter.sv - scoreboard bench for double_unit_arbiter with a double_neg unit model
module tb_double_unit_arbiter;
   import double_pkg::*;

   localparam logic [63:0] SIGN = 64'h8000000000000000;

   typedef struct {
      logic [1:0]  tag;
      logic [63:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [255:0]  req_data;
   logic [63:0]   unit_a;
   logic [63:0]   unit_z;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [63:0]   rsp_data;
   logic [1:0]    rsp_tag;
   logic          busy;

   logic [63:0]   lane_data [4];
   exp_t          exp_q [$];
   int            n_checks;
   int            n_errors;

   double_unit_arbiter #(
      .N_REQ      (4),
      .LATENCY    (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .unit_a    (unit_a),
      .unit_z    (unit_z),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // double_neg with one register stage
   always_ff @(posedge clk) begin
      unit_z <= unit_a ^ SIGN;
   end

   always_comb begin
      req_data = '0;
      for (int i = 0; i < 4; i++) begin
         req_data[64*i +: 64] = lane_data[i];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lane_of(input logic [3:0] onehot);
      int g;
      g = 0;
      for (int i = 0; i < 4; i++) begin
         if (onehot[i]) g = i;
      end
      return g;
   endfunction

   // monitor: pops on transfer, checks head against the scoreboard while stalled
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               check("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
               check("rsp_data", rsp_data, exp_q[0].data);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("idle_rsp_data", rsp_data, 64'd0);
            check("idle_rsp_tag", 64'(rsp_tag), 64'd0);
         end
      end
   end

   // wait until just after the next rising edge, the point where inputs change
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // one cycle with the expected grant; a grant records its expected result
   task automatic step(input logic [3:0] exp_ready);
      int g;
      @(negedge clk);
      g = lane_of(exp_ready);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (exp_ready != 4'b0) begin
         check("unit_a", unit_a, lane_data[g]);
         exp_q.push_back('{tag: 2'(g), data: lane_data[g] ^ SIGN});
      end else begin
         check("unit_a_idle", unit_a, 64'd0);
      end
      @(posedge clk);
      #1;
      if (exp_ready != 4'b0) lane_data[g] = lane_data[g] + 64'h0000000100000000;
   endtask

   // let every recorded result drain, bounded
   task automatic drain();
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("busy_after_drain", 64'(busy), 64'd0);
      sync();
   endtask

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) lane_data[i] = 64'h4000000000000000 + 64'(i);

      // reset state, with requests pending
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", rsp_data, 64'd0);
      check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_unit_a", unit_a, 64'd0);
      sync();
      rst_n     = 1'b1;
      req_valid = 4'b0;

      // single request on lane 2, +1.0 -> -1.0
      sync();
      lane_data[2] = POS_ONE;
      req_valid    = 4'b0100;
      step(4'b0100);
      req_valid = 4'b0;
      @(negedge clk);
      check("t1_not_yet_valid", 64'(rsp_valid), 64'd0);
      check("t1_busy_inflight", 64'(busy), 64'd1);
      @(negedge clk);
      check("t1_valid", 64'(rsp_valid), 64'd1);
      check("t1_data", rsp_data, NEG_ONE);
      check("t1_tag", 64'(rsp_tag), 64'd2);
      @(negedge clk);
      check("t1_busy_after_pop", 64'(busy), 64'd0);
      sync();

      // rr_ptr = 3, lanes 1 and 3: lane 3 first, then wrap to lane 1
      req_valid = 4'b1010;
      step(4'b1000);
      step(4'b0010);
      req_valid = 4'b0;
      drain();

      // rr_ptr = 2: serve lane 3 alone to bring rr_ptr back to 0
      req_valid = 4'b1000;
      step(4'b1000);

      // all lanes valid, sink always ready: strict rotation, no bubbles
      req_valid = 4'hF;
      for (int r = 0; r < 2; r++) begin
         step(4'b0001);
         step(4'b0010);
         step(4'b0100);
         step(4'b1000);
      end
      req_valid = 4'b0;
      drain();

      // sink stalled: exactly four accepts, then no grant until credit returns
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      step(4'b0001);
      step(4'b0010);
      step(4'b0100);
      step(4'b1000);
      step(4'b0000);
      step(4'b0000);
      rsp_ready = 1'b1;
      step(4'b0000);
      step(4'b0001);
      step(4'b0010);
      req_valid = 4'b0;
      drain();

      // special values: -0 -> +0, quiet NaN and payload NaN get their sign flipped
      lane_data[2] = 64'h8000000000000000;
      lane_data[3] = 64'h7FF8000000000000;
      lane_data[0] = 64'hFFF0000000000001;
      req_valid    = 4'b1101;
      step(4'b0100);
      step(4'b1000);
      step(4'b0001);
      req_valid = 4'b0;
      drain();

      // reset with one op queued and one in flight: everything is discarded
      rsp_ready = 1'b0;
      req_valid = 4'b0110;
      step(4'b0010);
      step(4'b0100);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_req_ready", 64'(req_ready), 64'd0);
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_rsp_data", rsp_data, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_unit_a", unit_a, 64'd0);
      sync();
      rst_n     = 1'b1;
      req_valid = 4'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      end
      sync();
      lane_data[2] = 64'hC008000000000000;
      req_valid    = 4'b0100;
      step(4'b0100);
      req_valid = 4'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
